// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for the 5-stage pipeline (memory wait > load-use > branch flush)
module pipeline_stall_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       edestReg,
  input  logic [4:0]       drs,
  input  logic [4:0]       drt,
  input  logic             d_uses_rs,
  input  logic             d_uses_rt,
  input  logic             branch_taken,
  input  logic             mmem_op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic load_use, err_set;
  assign load_use = ewreg & em2reg & (edestReg != 5'd0) &
                    ((d_uses_rs & (drs == edestReg)) | (d_uses_rt & (drt == edestReg)));
  always_comb begin
    state_n = state;
    wait_n = wait_cnt;
    err_set = 1'b0;
    mem_req = 1'b0;
    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
    ifid_flush = 1'b0;
    idex_bubble = 1'b0;
    memwb_bubble = 1'b0;
    if (reset) begin
      {ifid_flush, idex_bubble, memwb_bubble} = 3'b111;
      state_n = RUN;
      wait_n = '0;
    end else begin
      case (state)
        RUN: begin
          mem_req = mmem_op;
          if (mmem_op && !mem_ready) begin
            memwb_bubble = 1'b1;
            state_n = MEM_WAIT;
            wait_n = WW'(1);
          end else if (load_use) begin
            {idex_en, exmem_en, idex_bubble} = 3'b111;
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
            ifid_flush = branch_taken;
          end
        end
        MEM_WAIT: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
            ifid_flush = branch_taken;
            state_n = RUN;
          end else begin
            memwb_bubble = 1'b1;
            state_n = (wait_cnt == WW'(MAX_WAIT)) ? ERROR : MEM_WAIT;
            err_set = (wait_cnt == WW'(MAX_WAIT));
            wait_n = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
          end
        end
        default: {idex_bubble, memwb_bubble} = 2'b11;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_err <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_n;
      if (err_set) mem_err <= 1'b1;
      if (!pc_en && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed + random stimulus against a cycle-level reference model
module tb_pipeline_stall_ctrl;
  localparam int MAX_WAIT = 15;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, ewreg, em2reg, d_uses_rs, d_uses_rt, branch_taken, mmem_op, mem_ready;
  logic [4:0] edestReg, drs, drt;
  logic mem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble, mem_err;
  logic [15:0] sc16;
  logic s_req, s_pc, s_ifid, s_idex, s_exmem, s_fl, s_ib, s_mb, s_err;
  logic [3:0] sc4;
  int vectors = 0, errors = 0;
  int n, c16, c4;
  bit err;

  pipeline_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
    .clock(clk), .reset(reset), .ewreg(ewreg), .em2reg(em2reg), .edestReg(edestReg),
    .drs(drs), .drt(drt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .branch_taken(branch_taken), .mmem_op(mmem_op), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_count(sc16));

  pipeline_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut_w4 (
    .clock(clk), .reset(reset), .ewreg(ewreg), .em2reg(em2reg), .edestReg(edestReg),
    .drs(drs), .drt(drt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .branch_taken(branch_taken), .mmem_op(mmem_op), .mem_ready(mem_ready),
    .mem_req(s_req), .pc_en(s_pc), .ifid_en(s_ifid), .idex_en(s_idex),
    .exmem_en(s_exmem), .ifid_flush(s_fl), .idex_bubble(s_ib),
    .memwb_bubble(s_mb), .mem_err(s_err), .stall_count(sc4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit ew, input bit em, input bit [4:0] ed,
                      input bit [4:0] rs, input bit [4:0] rt, input bit ur, input bit ut,
                      input bit br, input bit mo, input bit mr);
    bit rq, pe, ie, xe, me, fl, ib, mb, lu;
    reset = r; ewreg = ew; em2reg = em; edestReg = ed; drs = rs; drt = rt;
    d_uses_rs = ur; d_uses_rt = ut; branch_taken = br; mmem_op = mo; mem_ready = mr;
    {rq, pe, ie, xe, me, fl, ib, mb} = 8'b0;
    lu = ew && em && ed != 0 && ((ur && rs == ed) || (ut && rt == ed));
    if (r) {fl, ib, mb} = 3'b111;
    else if (err) {ib, mb} = 2'b11;
    else if (n > 0) begin
      rq = 1'b1;
      if (mr) begin {pe, ie, xe, me} = 4'b1111; fl = br; end
      else mb = 1'b1;
    end else begin
      rq = mo;
      if (mo && !mr) mb = 1'b1;
      else if (lu) {xe, me, ib} = 3'b111;
      else begin {pe, ie, xe, me} = 4'b1111; fl = br; end
    end
    @(negedge clk);
    check("ctl", {23'b0, mem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble, mem_err},
          {23'b0, rq, pe, ie, xe, me, fl, ib, mb, err});
    check("ctl_w4", {23'b0, s_req, s_pc, s_ifid, s_idex, s_exmem, s_fl, s_ib, s_mb, s_err},
          {23'b0, rq, pe, ie, xe, me, fl, ib, mb, err});
    check("stall_count", {16'b0, sc16}, c16);
    check("stall_count_w4", {28'b0, sc4}, c4);
    if (r) begin
      n = 0; err = 0; c16 = 0; c4 = 0;
    end else begin
      if (!pe) begin
        c16 = (c16 == 65535) ? c16 : c16 + 1;
        c4 = (c4 == 15) ? c4 : c4 + 1;
      end
      if (!err) begin
        if (n > 0) begin
          if (mr) n = 0;
          else if (n == MAX_WAIT) begin err = 1; n = 0; end
          else n++;
        end else if (mo && !mr) n = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    {reset, ewreg, em2reg, d_uses_rs, d_uses_rt, branch_taken, mmem_op, mem_ready} = 8'h80;
    edestReg = 0; drs = 0; drt = 0;
    repeat (2) @(posedge clk);
    #1;
    n = 0; err = 0; c16 = 0; c4 = 0;
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 5, 5, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 7, 1, 7, 0, 1, 1, 0, 0);
    repeat (3) step(0, 1, 1, 5, 5, 0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (20) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) < 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
